matmul_reg_bank: RTL and testbench
==================================

# matmul_reg_bank

Register bank sitting directly downstream of the matmul APB slave: it decodes the slave's address/data/strobe write stream into control, operand, flags and scratchpad storage, and returns read data to the slave. It owns the start-bit handshake between software and the matmul engine, including a watchdog that aborts a run when the engine never reports done. The engine side writes flags and scratchpad results through a dedicated port.

## Interface
- DATA_WIDTH, 32, lane width; one strobe bit per lane
- BUS_WIDTH, 64, register/bus width; MAX_DIM = BUS_WIDTH/DATA_WIDTH lanes
- ADDR_WIDTH, 32, address width
- SP_DEPTH, 4, scratchpad entries (power of two)
- TIMEOUT_CYC, 1024, watchdog limit in cycles (>=2)

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- wr_en_i  in  1  one-cycle write request from APB slave
- wr_strb_i  in  MAX_DIM  per-lane write enables
- addr_i  in  ADDR_WIDTH  register address (reads and writes)
- wdata_i  in  BUS_WIDTH  write data
- rdata_o  out  BUS_WIDTH  read data for addr_i (combinational)
- start_bit_o  out  1  run request to engine and APB slave
- op_a_o, op_b_o  out  BUS_WIDTH each  operand registers
- done_i  in  1  engine completion pulse
- flags_we_i  in  1  engine flags write
- flags_i  in  BUS_WIDTH  engine flags value (bits [1:0] ignored)
- sp_we_i  in  1  engine scratchpad write
- sp_idx_i  in  log2(SP_DEPTH)  scratchpad entry index
- sp_wdata_i  in  BUS_WIDTH  scratchpad write data

## Operation
- Map on addr_i[4:0]: 0x00 CTRL, 0x04 OPA, 0x08 OPB, 0x0C FLAGS, >=0x10 SP; SP index = ((addr_i-0x10)>>3) mod SP_DEPTH (wraps).
- APB writes: only CTRL/OPA/OPB; each lane b updated iff wr_strb_i[b]. FLAGS and SP writes silently dropped. All APB writes dropped while start_bit_o=1.
- CTRL: bit0 = start, other bits read 0. Write with wr_strb_i[0]=1, wdata_i[0]=1 while idle -> start_bit_o=1 next cycle; also clears FLAGS[1:0] and watchdog counter. wdata_i[0]=0 is a no-op.
- States: IDLE (start_bit_o=0), RUN (start_bit_o=1). RUN->IDLE on done_i (FLAGS[0]<=1) or watchdog expiry (FLAGS[1]<=1). done_i in IDLE ignored.
- Watchdog: counter increments each RUN cycle; when it reaches TIMEOUT_CYC-1 without done_i, next edge -> IDLE, FLAGS[1]=1. done_i on the expiry cycle wins: FLAGS[0]=1, FLAGS[1]=0.
- FLAGS[BUS_WIDTH-1:2] written from flags_i on flags_we_i in any state; bits [1:0] owned by the block only.
- SP written only by engine (sp_we_i), any state. Same-cycle sp_we_i and read of same entry returns old value.
- Reads: rdata_o = selected register; CTRL reads {0,start_bit_o}; reads never side-effect.

## Timing
- Reset (rst_i high at edge): start_bit_o=0, op_a_o=op_b_o=0, FLAGS=0, all SP entries=0, counter=0, state IDLE; rdata_o then reflects zeros. Reset mid-RUN aborts with no flag set.
- Write latency: register/output visible one cycle after wr_en_i edge.
- Read latency: zero (combinational on addr_i and current register state).
- Start-to-expiry: start_bit_o high exactly TIMEOUT_CYC cycles if done_i never arrives.
- Simultaneous done_i and CTRL start write: done_i processed, write dropped, state IDLE.
- Simultaneous flags_we_i and done_i: both applied (disjoint bits).

## Test plan
- Reset, then read 0x00/0x04/0x0C/0x10 -> all 0; start_bit_o=0.
- Write OPA=0x1111_2222_3333_4444 strb=2'b01, then strb=2'b10 with 0xAAAA_BBBB_CCCC_DDDD -> op_a_o=0xAAAA_BBBB_3333_4444.
- Write CTRL=1 -> start_bit_o=1 next cycle; OPB write during RUN dropped; done_i after 5 cycles -> start_bit_o=0, FLAGS read 0x1.
- TIMEOUT_CYC=8, start, no done_i -> start_bit_o high 8 cycles, FLAGS=0x2; done_i on cycle 8 instead -> FLAGS=0x1.
- Engine sp_we_i idx=3 data=0xDEAD; APB write to 0x28 dropped; read 0x28 -> 0xDEAD; read 0x30 (wrap to idx 0) -> 0.
- flags_we_i flags_i=0xFF after done -> FLAGS=0xFD; new start clears to 0xFC.

Source files
------------

// File: rtl/matmul_reg_bank.sv
// Register bank behind the matmul APB slave: control/operand/flags/scratchpad
// storage, the start-bit run handshake with the engine and its watchdog.
module matmul_reg_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int SP_DEPTH    = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int SP_IDX_W   = (SP_DEPTH > 1) ? $clog2(SP_DEPTH) : 1,
  localparam int CNT_W      = $clog2(TIMEOUT_CYC)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [MAX_DIM-1:0]    wr_strb_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [BUS_WIDTH-1:0]  wdata_i,
  output logic [BUS_WIDTH-1:0]  rdata_o,
  output logic                  start_bit_o,
  output logic [BUS_WIDTH-1:0]  op_a_o,
  output logic [BUS_WIDTH-1:0]  op_b_o,
  input  logic                  done_i,
  input  logic                  flags_we_i,
  input  logic [BUS_WIDTH-1:0]  flags_i,
  input  logic                  sp_we_i,
  input  logic [SP_IDX_W-1:0]   sp_idx_i,
  input  logic [BUS_WIDTH-1:0]  sp_wdata_i
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [BUS_WIDTH-1:0] OWN_MASK = BUS_WIDTH'(3);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] op_a_q, op_a_d;
  logic [BUS_WIDTH-1:0] op_b_q, op_b_d;
  logic [BUS_WIDTH-1:0] flags_q, flags_d;
  logic [BUS_WIDTH-1:0] sp_q [SP_DEPTH];
  logic [BUS_WIDTH-1:0] sp_d [SP_DEPTH];

  logic                 sp_sel;
  logic [SP_IDX_W-1:0]  rd_idx;
  logic                 is_ctrl, is_opa, is_opb, is_flags;
  logic                 wr_ok;

  // Anything at or above 0x10 is scratchpad; the index wraps modulo SP_DEPTH.
  assign sp_sel   = |addr_i[ADDR_WIDTH-1:4];
  assign rd_idx   = SP_IDX_W'((addr_i - ADDR_WIDTH'(16)) >> 3);
  assign is_ctrl  = !sp_sel && (addr_i[3:0] == 4'h0);
  assign is_opa   = !sp_sel && (addr_i[3:0] == 4'h4);
  assign is_opb   = !sp_sel && (addr_i[3:0] == 4'h8);
  assign is_flags = !sp_sel && (addr_i[3:0] == 4'hC);
  assign wr_ok    = wr_en_i && (state_q == ST_IDLE);

  assign start_bit_o = (state_q == ST_RUN);
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    flags_d = flags_q;
    sp_d    = sp_q;

    for (int b = 0; b < MAX_DIM; b++) begin
      if (wr_ok && wr_strb_i[b] && is_opa)
        op_a_d[b*DATA_WIDTH +: DATA_WIDTH] = wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
      if (wr_ok && wr_strb_i[b] && is_opb)
        op_b_d[b*DATA_WIDTH +: DATA_WIDTH] = wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    end

    // Engine owns the upper flag bits; the low two bits belong to the run FSM.
    if (flags_we_i)
      flags_d = (flags_i & ~OWN_MASK) | (flags_q & OWN_MASK);

    case (state_q)
      ST_IDLE: begin
        if (wr_ok && is_ctrl && wr_strb_i[0] && wdata_i[0]) begin
          state_d      = ST_RUN;
          cnt_d        = '0;
          flags_d[1:0] = 2'b00;
        end
      end
      ST_RUN: begin
        if (done_i) begin
          state_d    = ST_IDLE;
          flags_d[0] = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          flags_d[1] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sp_we_i)
      sp_d[sp_idx_i] = sp_wdata_i;
  end

  always_comb begin
    rdata_o = '0;
    if (sp_sel) begin
      rdata_o = sp_q[rd_idx];
    end else if (is_ctrl) begin
      rdata_o = {{(BUS_WIDTH-1){1'b0}}, start_bit_o};
    end else if (is_opa) begin
      rdata_o = op_a_q;
    end else if (is_opb) begin
      rdata_o = op_b_q;
    end else if (is_flags) begin
      rdata_o = flags_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      flags_q <= '0;
      for (int i = 0; i < SP_DEPTH; i++) sp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      flags_q <= flags_d;
      for (int i = 0; i < SP_DEPTH; i++) sp_q[i] <= sp_d[i];
    end
  end

endmodule

// File: tb/tb_matmul_reg_bank.sv
// Bench for matmul_reg_bank: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_matmul_reg_bank;

  localparam int DW = 32;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int SPD = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_en_i = 1'b0;
  logic [1:0]    wr_strb_i = '0;
  logic [AW-1:0] addr_i = '0;
  logic [BW-1:0] wdata_i = '0;
  logic [BW-1:0] rdata_o;
  logic          start_bit_o;
  logic [BW-1:0] op_a_o, op_b_o;
  logic          done_i = 1'b0;
  logic          flags_we_i = 1'b0;
  logic [BW-1:0] flags_i = '0;
  logic          sp_we_i = 1'b0;
  logic [1:0]    sp_idx_i = '0;
  logic [BW-1:0] sp_wdata_i = '0;

  int checks = 0;
  int failures = 0;

  matmul_reg_bank #(
    .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW),
    .SP_DEPTH(SPD), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_strb_i(wr_strb_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .start_bit_o(start_bit_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .done_i(done_i), .flags_we_i(flags_we_i), .flags_i(flags_i),
    .sp_we_i(sp_we_i), .sp_idx_i(sp_idx_i), .sp_wdata_i(sp_wdata_i)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic          m_run = 1'b0;
  logic [BW-1:0] m_opa = '0, m_opb = '0, m_flags = '0;
  logic [BW-1:0] m_sp [SPD];
  longint        edge_n = 0;
  longint        m_deadline = 0;
  bit            started = 1'b0;

  initial for (int i = 0; i < SPD; i++) m_sp[i] = '0;

  always @(posedge clk) begin
    edge_n++;
    started = 1'b1;
    if (rst_i) begin
      m_run = 1'b0; m_opa = '0; m_opb = '0; m_flags = '0;
      for (int i = 0; i < SPD; i++) m_sp[i] = '0;
    end else begin
      if (m_run) begin
        // A run lasts until done or until TMO cycles after the start edge.
        if (done_i) begin
          m_run = 1'b0; m_flags[0] = 1'b1;
        end else if (edge_n == m_deadline) begin
          m_run = 1'b0; m_flags[1] = 1'b1;
        end
      end else if (wr_en_i) begin
        if (addr_i == 0) begin
          if (wr_strb_i[0] && wdata_i[0]) begin
            m_run = 1'b1; m_deadline = edge_n + TMO; m_flags[1:0] = 2'b00;
          end
        end else if (addr_i == 4 || addr_i == 8) begin
          for (int b = 0; b < 2; b++)
            if (wr_strb_i[b]) begin
              if (addr_i == 4) m_opa[b*DW +: DW] = wdata_i[b*DW +: DW];
              else             m_opb[b*DW +: DW] = wdata_i[b*DW +: DW];
            end
        end
      end
      if (flags_we_i) m_flags[BW-1:2] = flags_i[BW-1:2];
      if (sp_we_i) m_sp[sp_idx_i] = sp_wdata_i;
    end
  end

  function automatic logic [BW-1:0] exp_read(input logic [AW-1:0] a);
    longint unsigned idx;
    if (a >= 32'h10) begin
      idx = ((longint'(a) - 16) >> 3) % SPD;
      return m_sp[idx];
    end
    case (a)
      32'h0:   return {63'd0, m_run};
      32'h4:   return m_opa;
      32'h8:   return m_opb;
      32'hC:   return m_flags;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_start", {63'd0, start_bit_o}, {63'd0, m_run});
      chk("cyc_opa", op_a_o, m_opa);
      chk("cyc_opb", op_b_o, m_opb);
      chk("cyc_rdata", rdata_o, exp_read(addr_i));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [BW-1:0] d, input logic [1:0] s);
    wr_en_i = 1'b1; addr_i = a; wdata_i = d; wr_strb_i = s;
    tick();
    wr_en_i = 1'b0; wr_strb_i = '0;
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [BW-1:0] exp);
    addr_i = a; #1;
    chk(name, rdata_o, exp);
  endtask

  int n_high;

  initial begin
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;

    read_chk("rst_ctrl", 32'h00, 64'h0);
    read_chk("rst_opa", 32'h04, 64'h0);
    read_chk("rst_flags", 32'h0C, 64'h0);
    read_chk("rst_sp0", 32'h10, 64'h0);
    chk("rst_start", {63'd0, start_bit_o}, 64'h0);

    apb_write(32'h04, 64'h1111_2222_3333_4444, 2'b01);
    apb_write(32'h04, 64'hAAAA_BBBB_CCCC_DDDD, 2'b10);
    chk("opa_lanes", op_a_o, 64'hAAAA_BBBB_3333_4444);
    chk("model_opa", m_opa, 64'hAAAA_BBBB_3333_4444);

    apb_write(32'h00, 64'h1, 2'b01);
    chk("start_set", {63'd0, start_bit_o}, 64'h1);
    apb_write(32'h08, 64'h55, 2'b11);
    chk("opb_dropped_run", op_b_o, 64'h0);
    tick(); tick(); tick();
    done_i = 1'b1; tick(); done_i = 1'b0;
    chk("done_clears_start", {63'd0, start_bit_o}, 64'h0);
    read_chk("flags_done", 32'h0C, 64'h1);

    // Watchdog: start high exactly TMO cycles without done.
    apb_write(32'h00, 64'h1, 2'b01);
    n_high = 0;
    while (start_bit_o && n_high < 50) begin n_high++; tick(); end
    chk("wd_high_cycles", 64'(n_high), 64'(TMO));
    read_chk("flags_timeout", 32'h0C, 64'h2);

    // done_i on the expiry cycle wins.
    apb_write(32'h00, 64'h1, 2'b01);
    repeat (TMO - 1) tick();
    chk("still_run_last", {63'd0, start_bit_o}, 64'h1);
    done_i = 1'b1; tick(); done_i = 1'b0;
    chk("expiry_done_stop", {63'd0, start_bit_o}, 64'h0);
    read_chk("flags_done_wins", 32'h0C, 64'h1);

    sp_we_i = 1'b1; sp_idx_i = 2'd3; sp_wdata_i = 64'hDEAD; tick(); sp_we_i = 1'b0;
    apb_write(32'h28, 64'h1234, 2'b11);
    read_chk("sp3_read", 32'h28, 64'hDEAD);
    read_chk("sp_wrap0", 32'h30, 64'h0);

    flags_we_i = 1'b1; flags_i = 64'hFF; tick(); flags_we_i = 1'b0;
    read_chk("flags_fd", 32'h0C, 64'hFD);
    chk("model_flags_fd", m_flags, 64'hFD);
    apb_write(32'h00, 64'h1, 2'b01);
    read_chk("flags_fc", 32'h0C, 64'hFC);
    done_i = 1'b1; tick(); done_i = 1'b0;

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      rst_i = ($urandom_range(0, 299) == 0);
      wr_en_i = ($urandom_range(0, 2) == 0);
      wr_strb_i = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      if (sel == 0) addr_i = 32'h0;
      else if (sel == 1) addr_i = ($urandom_range(0, 1) != 0) ? 32'h4 : 32'h8;
      else if (sel == 2) addr_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else addr_i = 32'($urandom_range(0, 8'h7F));
      wdata_i = {32'($urandom), 32'($urandom)};
      if (sel == 0 && $urandom_range(0, 3) != 0) wdata_i[0] = 1'b1;
      done_i = ($urandom_range(0, 9) == 0);
      flags_we_i = ($urandom_range(0, 7) == 0);
      flags_i = {32'($urandom), 32'($urandom)};
      sp_we_i = ($urandom_range(0, 3) == 0);
      sp_idx_i = 2'($urandom_range(0, 3));
      sp_wdata_i = {32'($urandom), 32'($urandom)};
      tick();
    end
    rst_i = 1'b0; wr_en_i = 1'b0; done_i = 1'b0; flags_we_i = 1'b0; sp_we_i = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
